// File: rtl/fir_pkg.sv
// Shared widths, saturation limit and FSM state type for the FIR result receiver.
package fir_pkg;
  localparam int FIR_OUT_W = 18;
  localparam int SAMPLE_W  = 16;
  localparam logic [FIR_OUT_W-1:0] SAT_MAX = 18'd65535;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fir_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Word storage with wrapping read/write pointers; occupancy is tracked by the caller.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/fir_result_rx.sv
// FIR result receiver: converts 18-bit results to 16 bits and queues them for a ready/valid sink.
//
// state     | meaning
// ST_EMPTY  | no stored words, m_valid low
// ST_ACTIVE | 0 < level < DEPTH
// ST_FULL   | level == DEPTH, further results are dropped unless popping
module fir_result_rx
  import fir_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       complete,
  input  logic [FIR_OUT_W-1:0]       fir_data,
  input  logic                       sat_en,
  output logic                       m_valid,
  output logic [SAMPLE_W-1:0]        m_data,
  input  logic                       m_ready,
  output logic                       src_accept,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [$clog2(DEPTH):0]     level,
  output logic [SAMPLE_W-1:0]        sample_cnt
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  fir_state_e state, state_next;
  logic [LW-1:0]       level_next;
  logic [SAMPLE_W-1:0] conv_word;
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic                push, pop, drop;

  assign pop  = m_valid && m_ready;
  assign push = complete && ((level < FULL_LVL) || pop);
  assign drop = complete && (level == FULL_LVL) && !pop;

  always_comb begin
    conv_word = fir_data[SAMPLE_W-1:0];
    if (sat_en && (fir_data > SAT_MAX)) conv_word = SAT_MAX[SAMPLE_W-1:0];
  end

  always_comb begin
    level_next = level;
    if (push && !pop)      level_next = level + 1'b1;
    else if (pop && !push) level_next = level - 1'b1;
  end

  sync_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (conv_word),
    .rdata (fifo_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY:  if (push) state_next = ST_ACTIVE;
      ST_ACTIVE: begin
        if (push && !pop && level == FULL_LVL - 1'b1) state_next = ST_FULL;
        else if (pop && !push && level == LW'(1))     state_next = ST_EMPTY;
      end
      ST_FULL:   if (pop && !push) state_next = ST_ACTIVE;
      default:   state_next = ST_EMPTY;
    endcase
  end

  // Storage is never reset, so the output word is forced to zero while empty.
  always_comb begin
    m_valid = (state != ST_EMPTY);
    m_data  = m_valid ? fifo_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level      <= '0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
      src_accept <= 1'b1;
    end else begin
      level      <= level_next;
      src_accept <= (DEPTH - int'(level_next)) > AFULL_MARGIN;
      if (push)         sample_cnt <= sample_cnt + 1'b1;
      if (drop)         overflow   <= 1'b1;
      else if (clr_ovf) overflow   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_result_rx.sv
// Randomized and directed bench for fir_result_rx against a queue-based reference model.
module tb_fir_result_rx;
  localparam int DEPTH = 8;
  localparam int AFULL_MARGIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        complete = 1'b0;
  logic [17:0] fir_data = '0;
  logic        sat_en = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
  logic        src_accept;
  logic        overflow;
  logic        clr_ovf = 1'b0;
  logic [3:0]  level;
  logic [15:0] sample_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] mq[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        m_acc = 1'b1;

  fir_result_rx #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
    .clk(clk), .rst(rst), .complete(complete), .fir_data(fir_data), .sat_en(sat_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .src_accept(src_accept),
    .overflow(overflow), .clr_ovf(clr_ovf), .level(level), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs, advances the reference model, and returns #1 after the edge.
  task automatic step(input bit c, input logic [17:0] d, input bit s, input bit r,
                      input bit clr, input bit rs);
    bit pop, push, drop, full;
    logic [15:0] word;
    complete = c; fir_data = d; sat_en = s; m_ready = r; clr_ovf = clr; rst = rs;
    if (rs) begin
      mq.delete(); m_ovf = 1'b0; m_cnt = '0; m_acc = 1'b1;
    end else begin
      pop  = (mq.size() > 0) && r;
      full = (mq.size() == DEPTH);
      drop = c && full && !pop;
      push = c && (!full || pop);
      word = (s && d > 18'd65535) ? 16'hFFFF : d[15:0];
      if (pop)  void'(mq.pop_front());
      if (push) begin mq.push_back(word); m_cnt = m_cnt + 16'd1; end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_acc = (DEPTH - mq.size()) > AFULL_MARGIN;
    end
    @(posedge clk); #1;
    complete = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
  endtask

  function automatic logic [15:0] head();
    return (mq.size() > 0) ? mq[0] : 16'h0000;
  endfunction

  task automatic test_reset();
    step(1, 18'h3FFFF, 0, 0, 0, 1);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 16'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0000", m_data); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (sample_cnt !== 16'd0) begin failures++; $display("FAIL reset_sample_cnt got=%0d exp=0", sample_cnt); end
    checks++; if (src_accept !== 1'b1) begin failures++; $display("FAIL reset_src_accept got=%b exp=1", src_accept); end
  endtask

  task automatic test_basic();
    step(1, 18'h00123, 0, 0, 0, 0);
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL basic_m_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 16'h0123) begin failures++; $display("FAIL basic_m_data got=%h exp=0123", m_data); end
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL basic_level got=%0d exp=1", level); end
    checks++; if (sample_cnt !== 16'd1) begin failures++; $display("FAIL basic_sample_cnt got=%0d exp=1", sample_cnt); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", m_valid); end
  endtask

  task automatic test_conversion();
    logic [17:0] din [5] = '{18'h2ABCD, 18'h2ABCD, 18'h0FFFF, 18'h10000, 18'h10000};
    bit          sin [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] exp [5] = '{16'hFFFF, 16'hABCD, 16'hFFFF, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      step(1, din[i], sin[i], 0, 0, 0);
      checks++;
      if (m_data !== exp[i]) begin
        failures++; $display("FAIL conv_%0d got=%h exp=%h", i, m_data, exp[i]);
      end
      step(0, 0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      step(1, 18'(i), 0, 0, 0, 0);
      checks++;
      if (src_accept !== m_acc) begin
        failures++; $display("FAIL ovf_src_accept_push%0d got=%b exp=%b", i, src_accept, m_acc);
      end
    end
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL ovf_level got=%0d exp=8", level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (sample_cnt !== 16'd8) begin failures++; $display("FAIL ovf_sample_cnt got=%0d exp=8", sample_cnt); end
    checks++; if (m_data !== 16'd1) begin failures++; $display("FAIL ovf_head got=%h exp=0001", m_data); end
    step(1, 18'd10, 0, 1, 0, 0);
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL full_pushpop_level got=%0d exp=8", level); end
    checks++; if (sample_cnt !== 16'd9) begin failures++; $display("FAIL full_pushpop_cnt got=%0d exp=9", sample_cnt); end
    step(1, 18'd11, 0, 0, 1, 0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_with_drop got=%b exp=1", overflow); end
    step(0, 0, 0, 0, 1, 0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clr_alone got=%b exp=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = (i < 7) ? 16'(i + 2) : 16'd10;
      checks++;
      if (m_data !== e) begin failures++; $display("FAIL drain_%0d got=%h exp=%h", i, m_data, e); end
      step(0, 0, 0, 1, 0, 0);
    end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 18'($urandom), 0, 0, 0, 0);
    step(1, 18'h00055, 0, 0, 0, 1);
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", level); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL midrst_m_valid got=%b exp=0", m_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b exp=0", overflow); end
    checks++; if (sample_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", sample_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [17:0] d;
      d = ($urandom_range(0, 3) == 0) ? 18'($urandom_range(65530, 65541)) : 18'($urandom);
      step($urandom_range(0, 9) < 7, d, 1'($urandom), $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
      checks++;
      if (m_valid !== (mq.size() > 0) || m_data !== head() || level !== 4'(mq.size()) ||
          overflow !== m_ovf || sample_cnt !== m_cnt || src_accept !== m_acc) begin
        failures++;
        $display("FAIL random_%0d got v=%b d=%h l=%0d o=%b c=%0d a=%b exp v=%b d=%h l=%0d o=%b c=%0d a=%b",
                 n, m_valid, m_data, level, overflow, sample_cnt, src_accept,
                 mq.size() > 0, head(), mq.size(), m_ovf, m_cnt, m_acc);
      end
    end
  endtask

  task automatic test_cnt_wrap();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65535; i++) step(1, 18'(i), 0, 1, 0, 0);
    checks++; if (sample_cnt !== 16'hFFFF) begin failures++; $display("FAIL cnt_preload got=%0d exp=65535", sample_cnt); end
    step(1, 18'h1, 0, 1, 0, 0);
    checks++; if (sample_cnt !== 16'h0000) begin failures++; $display("FAIL cnt_wrap got=%0d exp=0", sample_cnt); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL cnt_wrap_ovf got=%b exp=0", overflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conversion();
    test_overflow();
    test_reset_mid();
    test_random();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
